gpio_input_conditioner: RTL and testbench

// - Conditions raw board inputs (buttons, switches, external IRQ lines) before they reach lt16soc_top.
// - Provides synchronisation, per-bit debounce, button edge pulses, and sticky IRQ pending bits with ack.
// - Sits between the pads and the SoC btn/sw/test_irq inputs.
// - Keeps metastable or bouncing levels out of the core and its interrupt controller.

---
 rtl/gpio_cond_pkg.sv | 18 +
 rtl/debounce_bit.sv | 62 ++++++
 rtl/gpio_input_conditioner.sv | 90 +++++++++
 tb/tb_gpio_input_conditioner.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_cond_pkg.sv
// Shared types and helpers for the GPIO input conditioner.
// Counter widths are derived from the debounce length so the counter never needs to wrap.
package gpio_cond_pkg;

  localparam int DEFAULT_DEBOUNCE = 1000;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_DEBOUNCE);

  typedef struct packed {
    logic                     stable;
    logic [DEFAULT_CNT_W-1:0] cnt;
  } debounce_state_t;

endpackage

// File: rtl/debounce_bit.sv
// One conditioned input bit: multi-flop synchroniser followed by a debounce counter.
// The output only changes after the synced level has differed for DEBOUNCE_CYCLES cycles in a row.
module debounce_bit
  import gpio_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Same layout as debounce_state_t, sized for this instance's debounce length.
  typedef struct packed {
    logic             stable;
    logic [CNT_W-1:0] cnt;
  } bit_state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  bit_state_t             state_q;
  bit_state_t             state_d;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Any return to the stable level restarts the qualification window.
  always_comb begin
    state_d = state_q;
    if (synced == state_q.stable) begin
      state_d.cnt = '0;
    end else if (state_q.cnt == CNT_LAST) begin
      state_d.stable = synced;
      state_d.cnt    = '0;
    end else begin
      state_d.cnt = state_q.cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign level = state_q.stable;

endmodule

// File: rtl/gpio_input_conditioner.sv
// Conditions raw pads for the SoC: debounced buttons/switches with change pulses,
// and synchronised IRQ lines latched into sticky pending bits with per-bit ack.
module gpio_input_conditioner
  import gpio_cond_pkg::*;
#(
  parameter int NUM_BTN         = 2,
  parameter int NUM_SW          = 8,
  parameter int NUM_IRQ         = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic               clk_sys,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_SW-1:0]  sw_raw,
  input  logic [NUM_IRQ-1:0] irq_raw,
  output logic [NUM_BTN-1:0] btn_o,
  output logic [NUM_BTN-1:0] btn_rise,
  output logic [NUM_SW-1:0]  sw_o,
  output logic               sw_changed,
  output logic [NUM_IRQ-1:0] irq_pending,
  input  logic [NUM_IRQ-1:0] irq_ack
);

  localparam int NUM_DB = NUM_BTN + NUM_SW;

  logic [NUM_DB-1:0] db_raw;
  logic [NUM_DB-1:0] db_level;

  assign db_raw = {sw_raw, btn_raw};

  for (genvar i = 0; i < NUM_DB; i++) begin : g_db
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_sys(clk_sys),
      .rst    (rst),
      .raw    (db_raw[i]),
      .level  (db_level[i])
    );
  end

  assign btn_o = db_level[NUM_BTN-1:0];
  assign sw_o  = db_level[NUM_DB-1:NUM_BTN];

  logic [NUM_BTN-1:0] btn_d;
  logic [NUM_SW-1:0]  sw_d;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      btn_d      <= '0;
      btn_rise   <= '0;
      sw_d       <= '0;
      sw_changed <= 1'b0;
    end else begin
      btn_d      <= btn_o;
      btn_rise   <= btn_o & ~btn_d;
      sw_d       <= sw_o;
      sw_changed <= |(sw_o ^ sw_d);
    end
  end

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] irq_sync_q;
  logic [NUM_IRQ-1:0]                  irq_s;
  logic [NUM_IRQ-1:0]                  irq_d;
  logic [NUM_IRQ-1:0]                  irq_rise;
  logic [SYNC_STAGES:0]                warm_q;

  assign irq_s = irq_sync_q[SYNC_STAGES-1];

  // Edges are ignored until both irq_s and irq_d hold real pad samples,
  // so a line already high at reset release is treated as a level, not an event.
  assign irq_rise = irq_s & ~irq_d & {NUM_IRQ{warm_q[SYNC_STAGES]}};

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      irq_sync_q  <= '0;
      irq_d       <= '0;
      warm_q      <= '0;
      irq_pending <= '0;
    end else begin
      irq_sync_q  <= {irq_sync_q[SYNC_STAGES-2:0], irq_raw};
      irq_d       <= irq_s;
      warm_q      <= {warm_q[SYNC_STAGES-1:0], 1'b1};
      irq_pending <= irq_rise | (irq_pending & ~irq_ack);
    end
  end

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Bench for gpio_input_conditioner: directed scenarios plus random pad activity,
// all outputs compared every cycle against a window-based reference model.
module tb_gpio_input_conditioner;

  localparam int NB   = 2;
  localparam int NS   = 8;
  localparam int NI   = 2;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int NDB  = NB + NS;
  localparam int NW   = NDB + NI;
  localparam int HMAX = 8192;

  logic          clk_sys;
  logic          rst;
  logic [NB-1:0] btn_raw;
  logic [NS-1:0] sw_raw;
  logic [NI-1:0] irq_raw;
  logic [NI-1:0] irq_ack;
  logic [NB-1:0] btn_o;
  logic [NB-1:0] btn_rise;
  logic [NS-1:0] sw_o;
  logic          sw_changed;
  logic [NI-1:0] irq_pending;

  int vec_count  = 0;
  int miscompares = 0;

  gpio_input_conditioner #(
    .NUM_BTN        (NB),
    .NUM_SW         (NS),
    .NUM_IRQ        (NI),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .sw_raw     (sw_raw),
    .irq_raw    (irq_raw),
    .btn_o      (btn_o),
    .btn_rise   (btn_rise),
    .sw_o       (sw_o),
    .sw_changed (sw_changed),
    .irq_pending(irq_pending),
    .irq_ack    (irq_ack)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, want %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NB-1:0] btn, input logic [NS-1:0] sw,
                               input logic [NI-1:0] irq, input logic [NI-1:0] ack);
    btn_raw = btn;
    sw_raw  = sw;
    irq_raw = irq;
    irq_ack = ack;
  endtask

  // Reference model. Edge n (counted from reset release) samples the pads into
  // samp_h[n]; the synced level after edge k is the pad sample taken SYNC-1 edges earlier.
  // A debounced level flips at edge n when the DEB synced values seen after edges
  // n-DEB .. n-1 all differ from it. IRQ pending is set by a 0->1 of the synced level.
  logic [NW-1:0]  samp_h [HMAX];
  logic [NDB-1:0] deb_h  [HMAX];
  logic [NI-1:0]  pend_h [HMAX];
  int n = 0;

  function automatic logic [NW-1:0] synced_at(input int k);
    int idx;
    idx = k - SYNC + 1;
    if (idx >= 1) return samp_h[idx];
    return '0;
  endfunction

  function automatic logic [NDB-1:0] deb_at(input int k);
    if (k >= 0) return deb_h[k];
    return '0;
  endfunction

  always @(posedge clk_sys or posedge rst) begin
    logic [NDB-1:0] nxt;
    logic [NW-1:0]  s_now;
    logic [NW-1:0]  s_old;
    logic [NW-1:0]  sk;
    logic [NI-1:0]  rise;
    logic           all_diff;
    if (rst) begin
      n = 0;
      deb_h[0]  = '0;
      pend_h[0] = '0;
    end else if (n < HMAX - 1) begin
      n = n + 1;
      samp_h[n] = {irq_raw, sw_raw, btn_raw};
      nxt = deb_h[n-1];
      for (int b = 0; b < NDB; b++) begin
        all_diff = 1'b1;
        for (int k = n - DEB; k <= n - 1; k++) begin
          sk = synced_at(k);
          if (sk[b] == deb_h[n-1][b]) all_diff = 1'b0;
        end
        if (all_diff) nxt[b] = ~deb_h[n-1][b];
      end
      deb_h[n] = nxt;
      s_now = synced_at(n - 1);
      s_old = synced_at(n - 2);
      rise  = (n >= SYNC + 2) ? (s_now[NW-1:NDB] & ~s_old[NW-1:NDB]) : '0;
      pend_h[n] = rise | (pend_h[n-1] & ~irq_ack);
    end
  end

  always @(negedge clk_sys) begin
    logic [NDB-1:0] d0;
    logic [NDB-1:0] d1;
    logic [NDB-1:0] d2;
    logic [NI-1:0]  p0;
    if (rst) begin
      d0 = '0; d1 = '0; d2 = '0; p0 = '0;
    end else begin
      d0 = deb_at(n);
      d1 = deb_at(n - 1);
      d2 = deb_at(n - 2);
      p0 = pend_h[n];
    end
    checkOutput("model_btn_o",       32'(btn_o),       32'(d0[NB-1:0]));
    checkOutput("model_btn_rise",    32'(btn_rise),    32'(d1[NB-1:0] & ~d2[NB-1:0]));
    checkOutput("model_sw_o",        32'(sw_o),        32'(d0[NDB-1:NB]));
    checkOutput("model_sw_changed",  32'(sw_changed),  32'(|(d1[NDB-1:NB] ^ d2[NDB-1:NB])));
    checkOutput("model_irq_pending", 32'(irq_pending), 32'(p0));
  end

  initial begin
    logic          seen;
    int            pulses;
    logic [NB-1:0] rb;
    logic [NS-1:0] rs;
    logic [NI-1:0] ri;
    logic [NI-1:0] ra;

    rst = 1'b1;
    applyStimulus(2'b00, 8'hFF, 2'b11, 2'b00);
    repeat (3) @(negedge clk_sys);
    checkOutput("reset_outputs",
                32'({btn_o, btn_rise, sw_o, sw_changed, irq_pending}), 32'd0);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk_sys);
    @(negedge clk_sys);
    checkOutput("sw_before_accept", 32'(sw_o), 32'h00);
    @(negedge clk_sys);
    checkOutput("sw_after_reset", 32'(sw_o), 32'hFF);
    checkOutput("sw_chg_early", 32'(sw_changed), 32'd0);
    @(negedge clk_sys);
    checkOutput("sw_chg_pulse", 32'(sw_changed), 32'd1);
    @(negedge clk_sys);
    checkOutput("sw_chg_single", 32'(sw_changed), 32'd0);
    checkOutput("irq_no_edge_after_reset", 32'(irq_pending), 32'd0);

    // Bounce: each level held for 2 cycles, shorter than the debounce window.
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus((i % 2 == 0) ? 2'b01 : 2'b00, 8'hFF, 2'b11, 2'b00);
      repeat (2) begin
        @(negedge clk_sys);
        seen = seen | btn_o[0] | btn_rise[0];
      end
    end
    repeat (8) begin
      @(negedge clk_sys);
      seen = seen | btn_o[0] | btn_rise[0];
    end
    checkOutput("bounce_reject", 32'(seen), 32'd0);

    applyStimulus(2'b01, 8'hFF, 2'b11, 2'b00);
    repeat (5) @(posedge clk_sys);
    @(negedge clk_sys);
    checkOutput("press_pre", 32'(btn_o[0]), 32'd0);
    @(negedge clk_sys);
    checkOutput("press_accept", 32'(btn_o[0]), 32'd1);
    checkOutput("press_rise_early", 32'(btn_rise[0]), 32'd0);
    @(negedge clk_sys);
    checkOutput("press_rise_pulse", 32'(btn_rise[0]), 32'd1);
    @(negedge clk_sys);
    checkOutput("press_rise_once", 32'(btn_rise[0]), 32'd0);

    applyStimulus(2'b00, 8'hFF, 2'b11, 2'b00);
    repeat (5) @(posedge clk_sys);
    @(negedge clk_sys);
    checkOutput("release_pre", 32'(btn_o[0]), 32'd1);
    @(negedge clk_sys);
    checkOutput("release_accept", 32'(btn_o[0]), 32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk_sys);
      seen = seen | btn_rise[0];
    end
    checkOutput("release_no_rise", 32'(seen), 32'd0);

    applyStimulus(2'b00, 8'hAA, 2'b00, 2'b00);
    repeat (12) @(negedge clk_sys);
    applyStimulus(2'b00, 8'h55, 2'b00, 2'b00);
    repeat (5) @(posedge clk_sys);
    @(negedge clk_sys);
    checkOutput("sw_pattern_pre", 32'(sw_o), 32'hAA);
    pulses = 0;
    @(negedge clk_sys);
    checkOutput("sw_pattern", 32'(sw_o), 32'h55);
    repeat (10) begin
      pulses = pulses + int'(sw_changed);
      @(negedge clk_sys);
    end
    checkOutput("sw_single_pulse", 32'(pulses), 32'd1);

    applyStimulus(2'b00, 8'h55, 2'b01, 2'b00);
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    checkOutput("irq_pre", 32'(irq_pending[0]), 32'd0);
    @(negedge clk_sys);
    checkOutput("irq_set", 32'(irq_pending[0]), 32'd1);
    repeat (7) @(negedge clk_sys);
    applyStimulus(2'b00, 8'h55, 2'b00, 2'b00);
    repeat (5) @(negedge clk_sys);
    checkOutput("irq_sticky", 32'(irq_pending[0]), 32'd1);
    applyStimulus(2'b00, 8'h55, 2'b00, 2'b01);
    @(negedge clk_sys);
    applyStimulus(2'b00, 8'h55, 2'b00, 2'b00);
    checkOutput("irq_ack_clear", 32'(irq_pending[0]), 32'd0);

    // Ack lands in the same cycle the rising edge is detected.
    applyStimulus(2'b00, 8'h55, 2'b10, 2'b00);
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    applyStimulus(2'b00, 8'h55, 2'b10, 2'b10);
    @(negedge clk_sys);
    applyStimulus(2'b00, 8'h55, 2'b10, 2'b00);
    checkOutput("set_ack_collision", 32'(irq_pending[1]), 32'd1);
    applyStimulus(2'b00, 8'h55, 2'b10, 2'b10);
    @(negedge clk_sys);
    applyStimulus(2'b00, 8'h55, 2'b10, 2'b00);
    repeat (4) @(negedge clk_sys);
    checkOutput("held_line_sets_once", 32'(irq_pending[1]), 32'd0);

    applyStimulus(2'b10, 8'h55, 2'b00, 2'b00);
    repeat (3) @(negedge clk_sys);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk_sys);
    checkOutput("midreset_outputs",
                32'({btn_o, btn_rise, sw_o, sw_changed, irq_pending}), 32'd0);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk_sys);
    @(negedge clk_sys);
    checkOutput("midreset_pre", 32'(btn_o[1]), 32'd0);
    @(negedge clk_sys);
    checkOutput("midreset_accept", 32'(btn_o[1]), 32'd1);
    @(negedge clk_sys);
    checkOutput("midreset_rise", 32'(btn_rise[1]), 32'd1);

    rb = btn_raw;
    rs = sw_raw;
    ri = irq_raw;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk_sys);
      for (int b = 0; b < NB; b++) if ($urandom_range(0, 11) == 0) rb[b] = ~rb[b];
      for (int b = 0; b < NS; b++) if ($urandom_range(0, 11) == 0) rs[b] = ~rs[b];
      for (int b = 0; b < NI; b++) begin
        if ($urandom_range(0, 5) == 0) ri[b] = ~ri[b];
        ra[b] = ($urandom_range(0, 4) == 0);
      end
      applyStimulus(rb, rs, ri, ra);
    end
    @(negedge clk_sys);
    applyStimulus(rb, rs, ri, 2'b00);
    repeat (12) @(negedge clk_sys);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
